// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, combinational next-PC lookup,
// same-cycle mispredict redirect from the EX stage and a saturating mispredict counter.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] fetch_pc,
    output logic [29:0] predict_pc,
    output logic        predict_taken,
    input  logic        upd_valid,
    input  logic [29:0] upd_pc,
    input  logic        upd_taken,
    input  logic [29:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [29:0] upd_pred_pc,
    output logic        pc_sel,
    output logic [29:0] adin,
    output logic [15:0] mispredict_cnt
);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_r  [ENTRIES];
    logic [TAG_W-1:0] tag_r    [ENTRIES];
    logic [29:0]      target_r [ENTRIES];
    logic [1:0]       ctr_r    [ENTRIES];
    logic [15:0]      cnt_r;

    logic [IDX_W-1:0] lk_idx_s;
    logic             lk_hit_s;
    logic             lk_taken_s;
    logic [IDX_W-1:0] up_idx_s;
    logic             up_hit_s;
    logic [29:0]      actual_next_s;
    logic             mispredict_s;

    // Fetch-side lookup: reads pre-edge table contents only.
    always_comb begin
        lk_idx_s   = fetch_pc[IDX_W-1:0];
        lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == fetch_pc[29:IDX_W]);
        lk_taken_s = lk_hit_s && ctr_r[lk_idx_s][1];
        if (lk_taken_s) begin
            predict_pc = target_r[lk_idx_s];
        end else begin
            predict_pc = fetch_pc + 30'd1;
        end
    end

    assign predict_taken = lk_taken_s;

    // Resolve side: compare the carried prediction against the real outcome.
    always_comb begin
        up_idx_s = upd_pc[IDX_W-1:0];
        up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == upd_pc[29:IDX_W]);
        if (upd_taken) begin
            actual_next_s = upd_target;
        end else begin
            actual_next_s = upd_pc + 30'd1;
        end
        mispredict_s = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (actual_next_s != upd_pred_pc));
        if (mispredict_s) begin
            adin = actual_next_s;
        end else begin
            adin = 30'd0;
        end
    end

    assign pc_sel = mispredict_s;

    // Table update; a not-taken miss leaves the table untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= 30'd0;
                ctr_r[i]    <= 2'd1;
            end
        end else if (upd_valid) begin
            if (up_hit_s) begin
                if (upd_taken) begin
                    target_r[up_idx_s] <= upd_target;
                    if (ctr_r[up_idx_s] != 2'd3) begin
                        ctr_r[up_idx_s] <= ctr_r[up_idx_s] + 2'd1;
                    end
                end else if (ctr_r[up_idx_s] != 2'd0) begin
                    ctr_r[up_idx_s] <= ctr_r[up_idx_s] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_r[up_idx_s]  <= 1'b1;
                tag_r[up_idx_s]    <= upd_pc[29:IDX_W];
                target_r[up_idx_s] <= upd_target;
                ctr_r[up_idx_s]    <= 2'd2;
            end
        end
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 16'd0;
        end else if (mispredict_s && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign mispredict_cnt = cnt_r;

endmodule
